// File: rtl/plot_sink_pkg.sv
// Shared constants and types for the plot_sink framebuffer writer.
// The address helper is defined here so that all users compute it the same way.
package plot_sink_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_WORDS = 19200;
  localparam int ADDR_W   = 15;

  localparam logic [ADDR_W-1:0] LAST_ADDR      = ADDR_W'(FB_WORDS - 1);
  localparam logic [14:0]       PLOT_COUNT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } fifo_entry_t;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] y_w;
    y_w = {8'd0, y};
    return (y_w << 7) + (y_w << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/plot_sink_fifo.sv
// plot_fifo: synchronous DEPTH-entry FIFO of plot entries with a combinational head,
// so an entry written on one edge is visible to the drain logic in the very next cycle.
module plot_fifo
  import plot_sink_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  fifo_entry_t             i_din,
  input  logic                    i_pop,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output fifo_entry_t             o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  fifo_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == FULL_CNT);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/plot_sink.sv
// plot_sink: queues VGA plot requests and drains them, or a full-screen clear,
// into a framebuffer write port that can apply backpressure through fb_ready.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        busy,
  output logic        overflow,
  output logic        oor,
  output logic [14:0] plot_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_next;
  logic          r_clear_pending;
  logic [14:0]   r_clr_addr;
  logic          r_overflow;
  logic          r_oor;
  logic [14:0]   r_plot_count;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fifo_entry_t   w_head;
  fifo_entry_t   w_din;
  logic          w_in_range;
  logic          w_plot_live;
  logic          w_push;
  logic          w_xfer;
  logic          w_pop;
  logic          w_clear_done;
  logic          w_drain_done;

  // Plots are swallowed without side effects once a clear has been requested.
  assign w_in_range   = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
  assign w_plot_live  = vga_plot && !r_clear_pending && (r_state != CLEAR);
  assign w_push       = w_plot_live && w_in_range && !w_full;
  assign w_din        = '{addr: calc_addr(vga_x, vga_y), colour: vga_colour};
  assign w_xfer       = fb_we && fb_ready;
  assign w_pop        = (r_state == DRAIN) && w_xfer;
  assign w_clear_done = (r_state == CLEAR) && w_xfer && (r_clr_addr == LAST_ADDR);
  // True when the FIFO will hold nothing after this edge.
  assign w_drain_done = !w_push && (w_empty || ((w_count == CNT_ONE) && w_pop));

  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // IDLE leaves on the accepting edge itself so the write appears one cycle later.
  always_comb begin
    w_state_next = r_state;
    fb_we        = 1'b0;
    fb_addr      = '0;
    fb_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (r_clear_pending && w_empty) w_state_next = CLEAR;
        else if (!w_empty || w_push)    w_state_next = DRAIN;
      end
      DRAIN: begin
        fb_we = !w_empty;
        if (!w_empty) begin
          fb_addr  = w_head.addr;
          fb_wdata = w_head.colour;
        end
        if (w_drain_done) w_state_next = r_clear_pending ? CLEAR : IDLE;
      end
      CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = r_clr_addr;
        if (w_clear_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_clear_pending <= 1'b0;
      r_clr_addr      <= '0;
      r_overflow      <= 1'b0;
      r_oor           <= 1'b0;
      r_plot_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear_done) begin
        r_clear_pending <= 1'b0;
        r_clr_addr      <= '0;
        r_overflow      <= 1'b0;
        r_oor           <= 1'b0;
        r_plot_count    <= '0;
      end else begin
        if (clear) r_clear_pending <= 1'b1;
        if ((r_state == CLEAR) && w_xfer) r_clr_addr <= r_clr_addr + 15'd1;
        if (w_plot_live && !w_in_range) r_oor <= 1'b1;
        if (w_plot_live && w_in_range && w_full) r_overflow <= 1'b1;
        if (w_push && (r_plot_count != PLOT_COUNT_MAX)) r_plot_count <= r_plot_count + 15'd1;
      end
    end
  end

  assign busy       = (r_state != IDLE) || !w_empty || r_clear_pending;
  assign overflow   = r_overflow;
  assign oor        = r_oor;
  assign plot_count = r_plot_count;
endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink: expected framebuffer writes are queued as stimulus
// is driven and matched in order against every accepted write.
module tb_plot_sink;
  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        fb_ready;
  logic        busy;
  logic        overflow;
  logic        oor;
  logic [14:0] plot_count;

  plot_sink #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clear      (clear),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .overflow   (overflow),
    .oor        (oor),
    .plot_count (plot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          xfer_cnt = 0;
  bit          toggle_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [2:0]  prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_en) fb_ready = !fb_ready;
  endtask

  task automatic plot(input int x, input int y, input int c, input bit accept);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    if (accept) sb.push_back({15'(y * 160 + x), 3'(c)});
    step();
    vga_plot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && busy; i++) step();
    check(tag, 32'(busy), 32'd0);
  endtask

  // Write monitor: sampled mid-cycle, so fb_we&&fb_ready here is the transfer at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_we", 32'(fb_we), 32'd1);
        check("hold_addr", 32'(fb_addr), 32'(prev_addr));
        check("hold_data", 32'(fb_wdata), 32'(prev_data));
      end
      prev_stall = fb_we && !fb_ready;
      prev_addr  = fb_addr;
      prev_data  = fb_wdata;
      if (fb_we && fb_ready) begin
        logic [17:0] exp_e;
        xfer_cnt++;
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_e = sb.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(exp_e[17:3]));
          check("wr_data", 32'(fb_wdata), 32'(exp_e[2:0]));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
    vga_plot = 1'b0; clear = 1'b0; fb_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_oor", 32'(oor), 32'd0);
    check("rst_count", 32'(plot_count), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);

    // Out-of-range plots are dropped and flagged
    plot(160, 0, 1, 1'b0);
    plot(0, 120, 1, 1'b0);
    step();
    check("oor_flag", 32'(oor), 32'd1);
    check("oor_count", 32'(plot_count), 32'd0);
    check("oor_overflow", 32'(overflow), 32'd0);
    check("oor_busy", 32'(busy), 32'd0);

    // Single plot, one-cycle latency
    plot(80, 94, 2, 1'b1);
    check("lat_we", 32'(fb_we), 32'd1);
    check("lat_addr", 32'(fb_addr), 32'd15120);
    check("lat_data", 32'(fb_wdata), 32'd2);
    step();
    check("single_we_off", 32'(fb_we), 32'd0);
    check("single_busy", 32'(busy), 32'd0);
    check("single_count", 32'(plot_count), 32'd1);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure fills the FIFO; the 17th plot overflows
    fb_ready = 1'b0;
    for (int x = 0; x < 17; x++) plot(x, 0, x % 8, x < 16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_count", 32'(plot_count), 32'd17);
    fb_ready = 1'b1;
    wait_idle(100, "ovf_drain_timeout");
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // fb_ready toggling each cycle while plots stream in
    toggle_en = 1'b1;
    plot(0, 0, 7, 1'b1);
    plot(159, 119, 5, 1'b1);
    plot(1, 1, 3, 1'b1);
    plot(10, 50, 6, 1'b1);
    plot(100, 20, 1, 1'b1);
    plot(159, 0, 4, 1'b1);
    wait_idle(100, "toggle_drain_timeout");
    toggle_en = 1'b0;
    fb_ready  = 1'b1;
    check("toggle_sb_empty", 32'(sb.size()), 32'd0);
    check("toggle_count", 32'(plot_count), 32'd23);
    check("toggle_ovf_sticky", 32'(overflow), 32'd1);

    // Clear with three plots queued; plots during pending clear are ignored
    fb_ready = 1'b0;
    plot(5, 5, 1, 1'b1);
    plot(6, 5, 2, 1'b1);
    plot(7, 5, 3, 1'b1);
    pulse_clear();
    plot(8, 5, 4, 1'b0);
    check("pend_count", 32'(plot_count), 32'd26);
    pulse_clear();
    for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'd0});
    fb_ready = 1'b1;
    wait_idle(25000, "clear_timeout");
    check("clear_sb_empty", 32'(sb.size()), 32'd0);
    check("clear_count", 32'(plot_count), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_oor", 32'(oor), 32'd0);
    repeat (3) step();
    check("clear_once_we", 32'(fb_we), 32'd0);
    check("clear_once_busy", 32'(busy), 32'd0);

    // Reset during the 100th clear write
    pulse_clear();
    for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'd0});
    base = xfer_cnt;
    for (int i = 0; i < 300 && xfer_cnt < base + 99; i++) step();
    check("rst_mid_progress", 32'(xfer_cnt - base), 32'd99);
    check("rst_mid_we", 32'(fb_we), 32'd1);
    check("rst_mid_addr", 32'(fb_addr), 32'd99);
    rst_n = 1'b0;
    step();
    check("rst_mid_we_off", 32'(fb_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr0", 32'(fb_addr), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    step();
    plot(80, 94, 2, 1'b1);
    check("post_rst_we", 32'(fb_we), 32'd1);
    check("post_rst_addr", 32'(fb_addr), 32'd15120);
    check("post_rst_data", 32'(fb_wdata), 32'd2);
    step();
    check("post_rst_we_off", 32'(fb_we), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_count", 32'(plot_count), 32'd1);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
